// File: rtl/iob_cache_front_end_q_pkg.sv
// ============================================================================
// iob_cache_front_end_q_pkg : shared types and sizing helpers for the queued front-end
// Revision: 1.0
// ============================================================================
`default_nettype none

package iob_cache_front_end_q_pkg;

    typedef enum logic {
        FE_SRC_DATA = 1'b0,
        FE_SRC_CTRL = 1'b1
    } fe_src_e;

    function automatic int fe_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Entry layout, MSB to LSB: {is_ctrl, addr, wdata, wstrb}
    function automatic int fe_entry_w(input int addr_w, input int data_w, input int use_ctrl);
        return 1 + (addr_w - use_ctrl) + data_w + (data_w / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_cache_front_end_q_fifo.sv
// ============================================================================
// iob_cache_front_end_q_fifo : DEPTH-entry register-array circular buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_cache_front_end_q_fifo
    import iob_cache_front_end_q_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = fe_ptr_w(DEPTH)
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         cke_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push, w_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign w_push  = cke_i & push_i & ~full_o;
    assign w_pop   = cke_i & pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/iob_cache_front_end_q.sv
// ============================================================================
// iob_cache_front_end_q : queued IOb front-end routing requests to data path / CSRs
// Optional performance counters enabled by defining IOB_CACHE_FE_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_cache_front_end_q
    import iob_cache_front_end_q_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int USE_CTRL    = 0,
    parameter int CSRS_ADDR_W = 5,
    parameter int DEPTH       = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       cke_i,
    input  logic                       iob_valid_i,
    input  logic [ADDR_W-1:0]          iob_addr_i,
    input  logic [DATA_W-1:0]          iob_wdata_i,
    input  logic [DATA_W/8-1:0]        iob_wstrb_i,
    output logic                       iob_ready_o,
    output logic                       iob_rvalid_o,
    output logic [DATA_W-1:0]          iob_rdata_o,
    output logic                       data_req_o,
    output logic [ADDR_W-USE_CTRL-1:0] data_addr_o,
    output logic [DATA_W-1:0]          data_wdata_o,
    output logic [DATA_W/8-1:0]        data_wstrb_o,
    input  logic [DATA_W-1:0]          data_rdata_i,
    input  logic                       data_ack_i,
    output logic                       ctrl_req_o,
    output logic [CSRS_ADDR_W-1:0]     ctrl_addr_o,
    input  logic [DATA_W-1:0]          ctrl_rdata_i,
    input  logic                       ctrl_ack_i
`ifdef IOB_CACHE_FE_PERF_EN
    ,
    input  logic                       perf_clr_i,
    output logic [31:0]                perf_req_cnt_o,
    output logic [31:0]                perf_stall_cnt_o
`endif
);

    localparam int DA_W     = ADDR_W - USE_CTRL;
    localparam int SW       = DATA_W / 8;
    localparam int ENTRY_W  = fe_entry_w(ADDR_W, DATA_W, USE_CTRL);
    localparam int CTRL_BIT = ENTRY_W - 1;
    localparam int WD_LSB   = SW;
    localparam int AD_LSB   = SW + DATA_W;

    logic               w_in_ctrl;
    logic [ENTRY_W-1:0] w_din, w_head;
    logic               w_full, w_empty, w_push, w_pop;
    fe_src_e            w_head_src;
    logic [DA_W-1:0]    w_head_addr;
    logic [SW-1:0]      w_head_wstrb;

    assign w_in_ctrl    = (USE_CTRL != 0) && iob_addr_i[ADDR_W-1];
    assign w_din        = {w_in_ctrl, iob_addr_i[DA_W-1:0], iob_wdata_i, iob_wstrb_i};

    assign w_head_src   = fe_src_e'(w_head[CTRL_BIT]);
    assign w_head_addr  = w_head[AD_LSB +: DA_W];
    assign w_head_wstrb = w_head[SW-1:0];

    // Ready depends only on queue occupancy, never on this cycle's ack.
    assign iob_ready_o  = ~w_full;
    assign w_push       = iob_valid_i & iob_ready_o;

    assign data_req_o   = ~w_empty & (w_head_src == FE_SRC_DATA);
    assign ctrl_req_o   = ~w_empty & (w_head_src == FE_SRC_CTRL);
    assign data_addr_o  = w_head_addr;
    assign data_wdata_o = w_head[WD_LSB +: DATA_W];
    assign data_wstrb_o = w_head_wstrb;

    assign w_pop        = cke_i & ((data_req_o & data_ack_i) | (ctrl_req_o & ctrl_ack_i));
    assign iob_rvalid_o = w_pop & (w_head_wstrb == '0);
    assign iob_rdata_o  = (w_head_src == FE_SRC_CTRL) ? ctrl_rdata_i : data_rdata_i;

    generate
        if (USE_CTRL != 0) begin : g_ctrl
            assign ctrl_addr_o = w_head_addr[CSRS_ADDR_W-1:0];
        end else begin : g_no_ctrl
            assign ctrl_addr_o = '0;
        end
    endgenerate

    iob_cache_front_end_q_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .push_i   (w_push),
        .pop_i    (w_pop),
        .din_i    (w_din),
        .dout_o   (w_head),
        .full_o   (w_full),
        .empty_o  (w_empty)
    );

`ifdef IOB_CACHE_FE_PERF_EN
    logic [31:0] perf_req_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            perf_req_q   <= '0;
            perf_stall_q <= '0;
        end else if (cke_i) begin
            if (perf_clr_i) begin
                perf_req_q   <= '0;
                perf_stall_q <= '0;
            end else begin
                if (w_push)                     perf_req_q   <= perf_req_q + 1'b1;
                if (iob_valid_i & ~iob_ready_o) perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_req_cnt_o   = perf_req_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iob_cache_front_end_q.sv
// ============================================================================
// tb_iob_cache_front_end_q : directed self-checking bench for the queued front-end
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iob_cache_front_end_q;

    logic        clk = 1'b0;
    logic        arst_n, cke, valid;
    logic [31:0] addr, wdata, data_rdata, ctrl_rdata;
    logic [3:0]  wstrb;
    logic        data_ack, ctrl_ack;

    logic        ready, rvalid, dreq, creq;
    logic [31:0] rdata, dwdata;
    logic [30:0] daddr;
    logic [3:0]  dwstrb;
    logic [4:0]  caddr;

    logic        u1_ready, u1_rvalid, u1_dreq, u1_creq;
    logic [31:0] u1_rdata, u1_dwdata, u1_daddr;
    logic [3:0]  u1_dwstrb;
    logic [4:0]  u1_caddr;

`ifdef IOB_CACHE_FE_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_req, perf_stall, u1_perf_req, u1_perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_cache_front_end_q #(
        .ADDR_W(32), .DATA_W(32), .USE_CTRL(1), .CSRS_ADDR_W(5), .DEPTH(4)
    ) u0 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(ready), .iob_rvalid_o(rvalid), .iob_rdata_o(rdata),
        .data_req_o(dreq), .data_addr_o(daddr), .data_wdata_o(dwdata), .data_wstrb_o(dwstrb),
        .data_rdata_i(data_rdata), .data_ack_i(data_ack),
        .ctrl_req_o(creq), .ctrl_addr_o(caddr), .ctrl_rdata_i(ctrl_rdata), .ctrl_ack_i(ctrl_ack)
`ifdef IOB_CACHE_FE_PERF_EN
        , .perf_clr_i(perf_clr), .perf_req_cnt_o(perf_req), .perf_stall_cnt_o(perf_stall)
`endif
    );

    iob_cache_front_end_q #(
        .ADDR_W(32), .DATA_W(32), .USE_CTRL(0), .CSRS_ADDR_W(5), .DEPTH(4)
    ) u1 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(u1_ready), .iob_rvalid_o(u1_rvalid), .iob_rdata_o(u1_rdata),
        .data_req_o(u1_dreq), .data_addr_o(u1_daddr), .data_wdata_o(u1_dwdata), .data_wstrb_o(u1_dwstrb),
        .data_rdata_i(data_rdata), .data_ack_i(data_ack),
        .ctrl_req_o(u1_creq), .ctrl_addr_o(u1_caddr), .ctrl_rdata_i(ctrl_rdata), .ctrl_ack_i(ctrl_ack)
`ifdef IOB_CACHE_FE_PERF_EN
        , .perf_clr_i(perf_clr), .perf_req_cnt_o(u1_perf_req), .perf_stall_cnt_o(u1_perf_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tail_a [3];
        tail_a = '{32'h10C, 32'h200, 32'h300};

        arst_n = 1'b0; cke = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        data_rdata = '0; data_ack = 1'b0; ctrl_rdata = '0; ctrl_ack = 1'b0;
`ifdef IOB_CACHE_FE_PERF_EN
        perf_clr = 1'b0;
`endif
        #12;
        check("reset_state", {ready, rvalid, dreq, creq}, 4'b1000);
        @(negedge clk);
        arst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle", {ready, rvalid, dreq, creq}, 4'b1000);
        end

        // Clock enable low blocks acceptance
        cke = 1'b0; valid = 1'b1; addr = 32'h40;
        tick();
        valid = 1'b0; cke = 1'b1;
        check("cke_no_push", dreq, 1'b0);

        // Fill with four reads, back-end stalled
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; addr = 32'(4 * i); wstrb = 4'h0;
            tick();
            check("fill_head_addr", daddr, 31'h0);
            check("fill_ready", ready, (i < 3) ? 1'b1 : 1'b0);
        end
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_ack = 1'b1; data_rdata = 32'hA0 + 32'(i);
            #1;
            check("drain_rvalid", rvalid, 1'b1);
            check("drain_rdata", rdata, 32'hA0 + 32'(i));
            check("drain_addr", daddr, 31'(4 * i));
            tick();
            check("drain_ready", ready, 1'b1);
        end
        data_ack = 1'b0;
        #1;
        check("drained_req", dreq, 1'b0);

        // Write followed by read
        valid = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        #1;
        check("no_bypass", dreq, 1'b0);
        tick();
        addr = 32'h14; wdata = '0; wstrb = 4'h0;
        tick();
        valid = 1'b0;
        #1;
        check("wr_wdata", dwdata, 32'hDEADBEEF);
        check("wr_wstrb", dwstrb, 4'hF);
        data_ack = 1'b1;
        #1;
        check("wr_no_rvalid", rvalid, 1'b0);
        tick();
        data_rdata = 32'h77;
        #1;
        check("rd_after_wr_rvalid", rvalid, 1'b1);
        check("rd_after_wr_rdata", rdata, 32'h77);
        check("rd_after_wr_addr", daddr, 31'h14);
        tick();
        data_ack = 1'b0;

        // CSR request routing
        valid = 1'b1; addr = 32'h8000_0004;
        #1;
        check("ctrl_no_bypass", creq, 1'b0);
        tick();
        valid = 1'b0; addr = '0;
        #1;
        check("ctrl_req", {creq, dreq}, 2'b10);
        check("ctrl_addr", caddr, 5'h04);
        check("nctrl_creq", u1_creq, 1'b0);
        check("nctrl_caddr", u1_caddr, 5'h00);
        check("nctrl_dreq", u1_dreq, 1'b1);
        check("nctrl_daddr", u1_daddr, 32'h8000_0004);
        data_ack = 1'b1; data_rdata = 32'h99;
        #1;
        check("stray_ack_rvalid", rvalid, 1'b0);
        tick();
        data_ack = 1'b0;
        #1;
        check("ctrl_held", creq, 1'b1);
        ctrl_ack = 1'b1; ctrl_rdata = 32'h55;
        #1;
        check("ctrl_rvalid", rvalid, 1'b1);
        check("ctrl_rdata", rdata, 32'h55);
        tick();
        ctrl_ack = 1'b0;
        #1;
        check("ctrl_popped", creq, 1'b0);

        // Full queue with valid held across a single ack
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; addr = 32'h100 + 32'(4 * i);
            tick();
        end
        addr = 32'h200;
        #1;
        check("full_ready", ready, 1'b0);
        data_ack = 1'b1; data_rdata = 32'hB0;
        #1;
        check("full_pop_rvalid", rvalid, 1'b1);
        check("full_pop_rdata", rdata, 32'hB0);
        check("full_pop_addr", daddr, 31'h100);
        tick();
        data_ack = 1'b0;
        #1;
        check("after_pop_ready", ready, 1'b1);
        tick();
        valid = 1'b0;
        #1;
        check("refull_ready", ready, 1'b0);
        check("refull_head", daddr, 31'h104);
        data_ack = 1'b1; data_rdata = 32'hC1;
        #1;
        check("seq_addr0", daddr, 31'h104);
        check("seq_rdata0", rdata, 32'hC1);
        tick();
        valid = 1'b1; addr = 32'h300; data_rdata = 32'hC2;
        #1;
        check("pushpop_addr", daddr, 31'h108);
        check("pushpop_rvalid", rvalid, 1'b1);
        tick();
        valid = 1'b0;
        #1;
        check("pushpop_ready", ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            data_rdata = 32'hD0 + 32'(i);
            #1;
            check("tail_addr", daddr, tail_a[i][30:0]);
            check("tail_rdata", rdata, 32'hD0 + 32'(i));
            tick();
        end
        data_ack = 1'b0;
        #1;
        check("tail_empty", {ready, dreq}, 2'b10);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; addr = 32'h400 + 32'(4 * i);
            tick();
        end
        valid = 1'b0;
        data_ack = 1'b1; data_rdata = 32'hE0;
        #1;
        check("pre_rst_rvalid", rvalid, 1'b1);
        arst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {ready, rvalid, dreq, creq}, 4'b1000);
        data_ack = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        check("rst_discard", {ready, rvalid, dreq, creq}, 4'b1000);

`ifdef IOB_CACHE_FE_PERF_EN
        check("perf_rst", {perf_req, perf_stall}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; addr = 32'h500 + 32'(4 * i);
            tick();
        end
        tick(); tick(); tick();
        check("perf_req", perf_req, 32'd4);
        check("perf_stall", perf_stall, 32'd3);
        perf_clr = 1'b1;
        tick();
        check("perf_clr", {perf_req, perf_stall}, 64'h0);
        perf_clr = 1'b0; valid = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
